// File: rtl/ram_sync_arbiter.sv
// Two-port round-robin front end for a single-port synchronous RAM.
// Zero-fills the array after reset, then serves one access per cycle.

module ram_sync_arbiter_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gnt,
  input  logic          we,
  input  logic [DW-1:0] ram_dato_s,
  output logic          rsp_valid,
  output logic [DW-1:0] rdata
);
  logic          vld_pipe;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= 1'b0;
      rdata_q  <= '0;
    end else begin
      vld_pipe <= gnt & ~we;
      if (vld_pipe) rdata_q <= ram_dato_s;
    end
  end

  // RAM output is already registered, so the response cycle passes it straight through
  assign rsp_valid = vld_pipe;
  assign rdata     = vld_pipe ? ram_dato_s : rdata_q;
endmodule

module ram_sync_arbiter #(
  parameter int AW             = 8,
  parameter int DW             = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rsp_valid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rsp_valid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_direccion,
  output logic [DW-1:0] ram_dato_e,
  output logic          ram_en,
  input  logic [DW-1:0] ram_dato_s,
  output logic          init_done
);
  localparam int NP = 2;

  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t                   state_q, state_d;
  logic [AW-1:0]            clr_addr, addr_q;
  logic                     last_grant;
  logic [NP-1:0]            req, we, gnt, rsp_valid;
  logic [NP-1:0][AW-1:0]    addr;
  logic [NP-1:0][DW-1:0]    wdata, rdata;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};
  assign gnt0  = gnt[0];
  assign gnt1  = gnt[1];
  assign rsp_valid0 = rsp_valid[0];
  assign rsp_valid1 = rsp_valid[1];
  assign rdata0 = rdata[0];
  assign rdata1 = rdata[1];

  always_comb begin
    state_d       = state_q;
    gnt           = '0;
    ram_en        = 1'b0;
    ram_direccion = addr_q;
    ram_dato_e    = '0;
    case (state_q)
      CLEAR: begin
        // Gate with rst_n so the fill strobe is quiet while reset is held
        ram_en        = rst_n;
        ram_direccion = clr_addr;
        if (clr_addr == '1) state_d = RUN;
      end
      default: begin
        if (init_done) begin
          if (req[0] && (!req[1] || last_grant)) gnt[0] = 1'b1;
          else if (req[1])                         gnt[1] = 1'b1;
        end
        if (gnt[0]) begin
          ram_direccion = addr[0];
          ram_dato_e    = wdata[0];
          ram_en        = we[0];
        end else if (gnt[1]) begin
          ram_direccion = addr[1];
          ram_dato_e    = wdata[1];
          ram_en        = we[1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_addr   <= '0;
      addr_q     <= '0;
      last_grant <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= ram_direccion;
      init_done <= init_done | (state_d == RUN);
      if (state_q == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (|gnt) last_grant <= gnt[1];
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    ram_sync_arbiter_port #(.DW(DW)) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .gnt        (gnt[p]),
      .we         (we[p]),
      .ram_dato_s (ram_dato_s),
      .rsp_valid  (rsp_valid[p]),
      .rdata      (rdata[p])
    );
  end
endmodule
